fsic_io_serdes_tx: RTL and testbench

FSIC_IO_SERDES_TX -- requirements
Module: fsic_io_serdes_tx

---
 rtl/fsic_serdes_pkg.sv | 16 +
 rtl/fsic_phase_lock_mon.sv | 59 +++++
 rtl/fsic_io_serdes_tx.sv | 75 +++++++
 tb/tb_fsic_io_serdes_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsic_serdes_pkg.sv
// fsic_serdes_pkg: lock-state encoding and slice-index sizing shared by the
// serdes transmit and receive sides.
package fsic_serdes_pkg;

  typedef enum logic {
    UNLOCK = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  localparam int LOSS_W = 8;

  function automatic int idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fsic_phase_lock_mon.sv
// fsic_phase_lock_mon: checks the ioclk-domain phase counter for a clean
// 0..N-1 sequence and declares lock after enough clean frames.
module fsic_phase_lock_mon import fsic_serdes_pkg::*; #(
  parameter int pCLK_RATIO   = 4,
  parameter int pLOCK_FRAMES = 2
) (
  input  logic                         ioclk,
  input  logic                         axis_rst_n,
  input  logic [idx_w(pCLK_RATIO)-1:0] phase_cnt_in,
  output logic                         clean,
  output logic                         locked,
  output logic [LOSS_W-1:0]            lock_loss_cnt
);
  localparam int PW = idx_w(pCLK_RATIO);
  localparam int CW = $clog2(pLOCK_FRAMES + 1);

  lock_state_e   state;
  logic [PW-1:0] prev;
  logic          prev_vld;
  logic          run_ok;
  logic          phase0;
  logic [CW-1:0] frame_cnt;

  assign phase0 = phase_cnt_in == '0;
  assign clean  = prev_vld && (phase_cnt_in == PW'(prev + 1'b1));
  assign locked = state == LOCKED;

  // run_ok: a phase 0 has been seen and every cycle since it was clean
  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state         <= UNLOCK;
      prev          <= '0;
      prev_vld      <= 1'b0;
      run_ok        <= 1'b0;
      frame_cnt     <= '0;
      lock_loss_cnt <= '0;
    end else begin
      prev     <= phase_cnt_in;
      prev_vld <= 1'b1;
      run_ok   <= phase0 || (run_ok && clean);
      if (state == UNLOCK) begin
        if (!clean) begin
          frame_cnt <= '0;
        end else if (phase0 && run_ok) begin
          if (frame_cnt == CW'(pLOCK_FRAMES - 1)) begin
            state     <= LOCKED;
            frame_cnt <= '0;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end else if (!clean) begin
        state         <= UNLOCK;
        lock_loss_cnt <= lock_loss_cnt + LOSS_W'(lock_loss_cnt != '1);
      end
    end
  end

endmodule

// File: rtl/fsic_io_serdes_tx.sv
// fsic_io_serdes_tx: serialises one coreclk-wide word into pCLK_RATIO ioclk
// slices, gated by phase lock, with a one-word holding register.
module fsic_io_serdes_tx import fsic_serdes_pkg::*; #(
  parameter int pCLK_RATIO   = 4,
  parameter int pDATA_WIDTH  = 8,
  parameter int pLOCK_FRAMES = 2
) (
  input  logic                              ioclk,
  input  logic                              axis_rst_n,
  input  logic [idx_w(pCLK_RATIO)-1:0]      phase_cnt_in,
  input  logic [pCLK_RATIO*pDATA_WIDTH-1:0] tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic [pDATA_WIDTH-1:0]            txd,
  output logic                              tx_frame,
  output logic                              tx_dv,
  output logic                              locked,
  output logic [LOSS_W-1:0]                 lock_loss_cnt
);
  localparam int WW = pCLK_RATIO * pDATA_WIDTH;

  logic          clean;
  logic          active;
  logic          phase0;
  logic          full;
  logic          load_now;
  logic          accept;
  logic [WW-1:0] hold;
  logic [WW-1:0] shifter;

  fsic_phase_lock_mon #(
    .pCLK_RATIO  (pCLK_RATIO),
    .pLOCK_FRAMES(pLOCK_FRAMES)
  ) u_lock_mon (
    .ioclk        (ioclk),
    .axis_rst_n   (axis_rst_n),
    .phase_cnt_in (phase_cnt_in),
    .clean        (clean),
    .locked       (locked),
    .lock_loss_cnt(lock_loss_cnt)
  );

  // A non-clean cycle while locked aborts the frame at once, so the held word
  // must not be moved into the shifter on that cycle or it would be lost.
  assign active   = locked && clean;
  assign phase0   = phase_cnt_in == '0;
  assign load_now = active && phase0 && full;
  assign tx_ready = locked && (!full || load_now);
  assign accept   = tx_valid && tx_ready;

  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      full     <= 1'b0;
      hold     <= '0;
      shifter  <= '0;
      txd      <= '0;
      tx_frame <= 1'b0;
      tx_dv    <= 1'b0;
    end else begin
      if (accept) begin
        hold <= tx_data;
        full <= 1'b1;
      end else if (load_now) begin
        full <= 1'b0;
      end
      if (load_now) shifter <= hold;
      tx_frame <= load_now;
      tx_dv    <= load_now || (active && !phase0 && tx_dv);
      txd      <= load_now ? hold[pDATA_WIDTH-1:0] :
                  (active && !phase0 && tx_dv) ? shifter[phase_cnt_in*pDATA_WIDTH +: pDATA_WIDTH] :
                  '0;
    end
  end

endmodule

// File: tb/tb_fsic_io_serdes_tx.sv
// tb_fsic_io_serdes_tx: randomized and directed checks of the serdes transmitter
// against a word-queue reference model.
module tb_fsic_io_serdes_tx;
  localparam int R  = 4;
  localparam int W  = 8;
  localparam int LF = 2;

  logic        ioclk = 1'b0;
  logic        axis_rst_n = 1'b1;
  logic [1:0]  phase_cnt_in = '0;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  txd;
  logic        tx_frame;
  logic        tx_dv;
  logic        locked;
  logic [7:0]  lock_loss_cnt;

  fsic_io_serdes_tx #(
    .pCLK_RATIO  (R),
    .pDATA_WIDTH (W),
    .pLOCK_FRAMES(LF)
  ) dut (
    .ioclk        (ioclk),
    .axis_rst_n   (axis_rst_n),
    .phase_cnt_in (phase_cnt_in),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .txd          (txd),
    .tx_frame     (tx_frame),
    .tx_dv        (tx_dv),
    .locked       (locked),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 ioclk = ~ioclk;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] cur;
  int          m_prev, m_run, m_loss, ph_next;
  bit          m_have_prev, m_locked, in_word;
  logic [18:0] exp_o, obs_o;
  logic        exp_rdy, obs_rdy;

  // One ioclk cycle with the given phase; the model tracks clean-run length
  // and the queue of accepted-but-unsent words.
  task automatic tick(input int ph);
    bit          m_clean, acc;
    logic        e_dv, e_fr;
    logic [7:0]  e_txd;
    phase_cnt_in = 2'(ph);
    tx_valid = src_q.size() > 0;
    tx_data  = tx_valid ? src_q[0] : $urandom;
    @(negedge ioclk);
    m_clean = m_have_prev && (ph == (m_prev + 1) % R);
    exp_rdy = m_locked && (exp_q.size() == 0 || (ph == 0 && m_clean));
    obs_rdy = tx_ready;
    acc = tx_valid && tx_ready;
    @(posedge ioclk);
    #1;
    {e_dv, e_fr, e_txd} = '0;
    if (!(m_locked && m_clean)) begin
      in_word = 0;
    end else if (ph == 0) begin
      in_word = exp_q.size() > 0;
      if (in_word) begin
        cur = exp_q.pop_front();
        {e_dv, e_fr, e_txd} = {2'b11, cur[7:0]};
      end
    end else if (in_word) begin
      {e_dv, e_fr, e_txd} = {2'b10, cur[ph*W +: W]};
    end
    m_run = m_clean ? m_run + 1 : 0;
    if (m_locked && !m_clean) begin
      m_locked = 0;
      m_loss = (m_loss == 255) ? 255 : m_loss + 1;
    end else if (!m_locked && ph == 0 && m_clean && m_run / R == LF) begin
      m_locked = 1;
    end
    if (acc) begin
      exp_q.push_back(tx_data);
      void'(src_q.pop_front());
    end
    m_prev = ph;
    m_have_prev = 1;
    ph_next = (ph + 1) % R;
    exp_o = {e_dv, e_fr, e_txd, m_locked, 8'(m_loss)};
    obs_o = {tx_dv, tx_frame, txd, locked, lock_loss_cnt};
  endtask

  task automatic test_reset;
    #2 axis_rst_n = 1'b0;
    #1;
    n_checks += 6;
    if (txd !== 8'h00) begin n_fail++; $display("FAIL reset txd: got %h want 00", txd); end
    if (tx_frame !== 1'b0) begin n_fail++; $display("FAIL reset tx_frame: got %b want 0", tx_frame); end
    if (tx_dv !== 1'b0) begin n_fail++; $display("FAIL reset tx_dv: got %b want 0", tx_dv); end
    if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset tx_ready: got %b want 0", tx_ready); end
    if (locked !== 1'b0) begin n_fail++; $display("FAIL reset locked: got %b want 0", locked); end
    if (lock_loss_cnt !== 8'h00) begin n_fail++; $display("FAIL reset lock_loss_cnt: got %h want 00", lock_loss_cnt); end
    repeat (2) @(posedge ioclk);
    #1 axis_rst_n = 1'b1;
    m_have_prev = 0; m_locked = 0; m_loss = 0; m_run = 0; in_word = 0; ph_next = 0;
  endtask

  task automatic test_lock;
    for (int i = 0; i < 9; i++) begin
      tick(i % R);
      n_checks++;
      if ({obs_o, obs_rdy} !== {exp_o, exp_rdy}) begin
        n_fail++; $display("FAIL lock tick %0d: got %h want %h", i, {obs_o, obs_rdy}, {exp_o, exp_rdy});
      end
      if (i == 7) begin
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL lock early: got %b want 0", locked); end
      end
    end
    n_checks++;
    if ({locked, tx_ready} !== 2'b11) begin
      n_fail++; $display("FAIL lock rise: locked/ready got %b want 11", {locked, tx_ready});
    end
  endtask

  task automatic test_single_word;
    logic [7:0] beats[$];
    logic [7:0] want[4];
    int         frames = 0;
    want = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    src_q.push_back(32'hDDCCBBAA);
    for (int i = 0; i < 8; i++) begin
      tick(ph_next);
      n_checks++;
      if ({obs_o, obs_rdy} !== {exp_o, exp_rdy}) begin
        n_fail++; $display("FAIL single tick %0d: got %h want %h", i, {obs_o, obs_rdy}, {exp_o, exp_rdy});
      end
      if (tx_dv === 1'b1) beats.push_back(txd);
      if (tx_frame === 1'b1) frames += (txd === 8'hAA) ? 1 : 100;
    end
    n_checks += 2;
    if (beats.size() != 4) begin n_fail++; $display("FAIL single beats: got %0d want 4", beats.size()); end
    else foreach (want[k]) if (beats[k] !== want[k]) begin
      n_fail++; $display("FAIL single slice %0d: got %h want %h", k, beats[k], want[k]);
    end
    if (frames != 1) begin n_fail++; $display("FAIL single tx_frame: got %0d want 1", frames); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] beats[$];
    int         run = 0, best = 0;
    src_q.push_back(32'h03020100);
    src_q.push_back(32'h07060504);
    for (int i = 0; i < 13; i++) begin
      tick(ph_next);
      n_checks++;
      if ({obs_o, obs_rdy} !== {exp_o, exp_rdy}) begin
        n_fail++; $display("FAIL b2b tick %0d: got %h want %h", i, {obs_o, obs_rdy}, {exp_o, exp_rdy});
      end
      run = (tx_dv === 1'b1) ? run + 1 : 0;
      best = (run > best) ? run : best;
      if (tx_dv === 1'b1) beats.push_back(txd);
    end
    n_checks += 2;
    if (best != 8) begin n_fail++; $display("FAIL b2b dv run: got %0d want 8", best); end
    if (beats.size() != 8) begin n_fail++; $display("FAIL b2b beats: got %0d want 8", beats.size()); end
    else foreach (beats[k]) if (beats[k] !== 8'(k)) begin
      n_fail++; $display("FAIL b2b slice %0d: got %h want %h", k, beats[k], 8'(k));
    end
  endtask

  task automatic test_idle;
    int dv_seen = 0;
    for (int i = 0; i < 2 * R; i++) begin
      tick(ph_next);
      n_checks++;
      if ({obs_o, obs_rdy} !== {exp_o, exp_rdy}) begin
        n_fail++; $display("FAIL idle tick %0d: got %h want %h", i, {obs_o, obs_rdy}, {exp_o, exp_rdy});
      end
      if (tx_dv !== 1'b0 || tx_frame !== 1'b0 || txd !== 8'h00) dv_seen++;
    end
    n_checks++;
    if (dv_seen != 0) begin n_fail++; $display("FAIL idle activity: got %0d busy cycles want 0", dv_seen); end
  endtask

  task automatic test_lock_loss;
    logic [7:0] beats[$];
    int         guard = 0;
    src_q.push_back(32'h44332211);
    src_q.push_back(32'h88776655);
    while (!(tx_frame === 1'b1) && guard < 20) begin
      tick(ph_next);
      guard++;
    end
    n_checks++;
    if (tx_frame !== 1'b1) begin n_fail++; $display("FAIL loss frame start: got %b want 1", tx_frame); end
    tick(1);
    tick(3);
    n_checks += 2;
    if ({obs_o, obs_rdy} !== {exp_o, exp_rdy}) begin
      n_fail++; $display("FAIL loss glitch: got %h want %h", {obs_o, obs_rdy}, {exp_o, exp_rdy});
    end
    if ({tx_dv, locked, lock_loss_cnt} !== {2'b00, 8'd1}) begin
      n_fail++; $display("FAIL loss state: dv/locked/cnt got %b/%b/%0d want 0/0/1", tx_dv, locked, lock_loss_cnt);
    end
    for (int i = 0; i < 17; i++) begin
      tick(ph_next);
      n_checks++;
      if ({obs_o, obs_rdy} !== {exp_o, exp_rdy}) begin
        n_fail++; $display("FAIL relock tick %0d: got %h want %h", i, {obs_o, obs_rdy}, {exp_o, exp_rdy});
      end
      if (tx_dv === 1'b1) beats.push_back(txd);
    end
    n_checks++;
    if (beats.size() != 4 || {beats[0], beats[1], beats[2], beats[3]} !== 32'h55667788) begin
      n_fail++; $display("FAIL relock word: got %0d beats want 55 66 77 88", beats.size());
    end
  endtask

  task automatic test_loss_saturate;
    for (int n = 0; n < 256; n++) begin
      while (ph_next != 1) tick(ph_next);
      tick(3);
      for (int i = 0; i < 9; i++) tick(ph_next);
      n_checks++;
      if ({obs_o, obs_rdy} !== {exp_o, exp_rdy}) begin
        n_fail++; $display("FAIL saturate iter %0d: got %h want %h", n, {obs_o, obs_rdy}, {exp_o, exp_rdy});
      end
    end
    n_checks++;
    if ({locked, lock_loss_cnt} !== {1'b1, 8'd255}) begin
      n_fail++; $display("FAIL saturate count: locked/cnt got %b/%0d want 1/255", locked, lock_loss_cnt);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      if (i < 380 && src_q.size() < 2 && $urandom_range(1, 0) == 1) src_q.push_back($urandom);
      tick(ph_next);
      n_checks++;
      if ({obs_o, obs_rdy} !== {exp_o, exp_rdy}) begin
        n_fail++; $display("FAIL random tick %0d: got %h want %h", i, {obs_o, obs_rdy}, {exp_o, exp_rdy});
      end
    end
    n_checks++;
    if (src_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL random drain: pending src %0d sent-queue %0d want 0/0", src_q.size(), exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_single_word;
    test_back_to_back;
    test_idle;
    test_lock_loss;
    test_loss_saturate;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
